// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, PC update selects,
// fetch state encoding and the conditional-branch test.
package cpu_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_ABS  = 2'b01,
        PC_REL  = 2'b10,
        PC_COND = 2'b11
    } pc_sel_t;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_REQ  = 1'b1
    } fetch_state_t;

    // A conditional branch is taken when none of the flags selected by MM are set.
    function automatic logic branch_taken(input logic [3:0] stat, input logic [3:0] mm);
        return (stat & mm) == 4'b0000;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: the fetch unit is the master, memory the slave.
interface fetch_unit_if #(
    parameter int PC_W = 16
);
    logic            IMEM_REQ;
    logic [PC_W-1:0] IMEM_ADDR;
    logic            IMEM_ACK;
    logic [31:0]     IMEM_RDATA;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_ACK,
        input  IMEM_RDATA
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_ACK,
        output IMEM_RDATA
    );
endinterface

// File: rtl/pc_next_calc.sv
// Next-PC computation for sequential, absolute, relative and conditional updates.
// Kept standalone so a future branch predictor can reuse it.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] pc,
    input  pc_sel_t         pc_sel,
    input  logic [PC_W-1:0] imm,
    input  logic [3:0]      stat,
    input  logic [3:0]      mm,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_rel;

    // IMM is already PC_W wide, so adding it modulo 2^PC_W is the signed offset.
    assign pc_inc = pc + PC_W'(1);
    assign pc_rel = pc + imm;

    always_comb begin
        next_pc = pc_inc;
        unique case (pc_sel)
            PC_SEQ:  next_pc = pc_inc;
            PC_ABS:  next_pc = imm;
            PC_REL:  next_pc = pc_rel;
            PC_COND: next_pc = branch_taken(stat, mm) ? pc_rel : pc_inc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over the IMEM req/ack port
// and holds the instruction register feeding the control FSM.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RST_F,
    input  logic            FETCH_EN,
    input  logic            PC_WE,
    input  logic [1:0]      PC_SEL,
    input  logic [3:0]      STAT,
    fetch_unit_if.master    imem,
    output logic [31:0]     IR,
    output logic [3:0]      OPCODE,
    output logic [3:0]      MM,
    output logic [PC_W-1:0] IMM,
    output logic            IR_VALID,
    output logic            BUSY,
    output logic [PC_W-1:0] PC
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic            fetch_start;
    logic            fetch_done;
    logic [PC_W-1:0] fa;
    logic [PC_W-1:0] pc_next;

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request is decoded from the state so an async reset drops it immediately.
    always_comb begin
        state_next  = state;
        fetch_start = 1'b0;
        fetch_done  = 1'b0;
        unique case (state)
            FETCH_IDLE: begin
                if (FETCH_EN) begin
                    fetch_start = 1'b1;
                    state_next  = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (imem.IMEM_ACK) begin
                    fetch_done = 1'b1;
                    state_next = FETCH_IDLE;
                end
            end
        endcase
    end

    assign imem.IMEM_REQ  = (state == FETCH_REQ);
    assign imem.IMEM_ADDR = fa;
    assign BUSY           = (state == FETCH_REQ);

    // FA captures the pre-update PC so later PC writes cannot disturb a fetch.
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            fa       <= RESET_PC;
            IR       <= '0;
            IR_VALID <= 1'b0;
        end else begin
            if (fetch_start) begin
                fa       <= PC;
                IR_VALID <= 1'b0;
            end
            if (fetch_done) begin
                IR       <= imem.IMEM_RDATA;
                IR_VALID <= 1'b1;
            end
        end
    end

    assign OPCODE = IR[31:28];
    assign MM     = IR[27:24];
    assign IMM    = IR[PC_W-1:0];

    pc_next_calc #(
        .PC_W (PC_W)
    ) u_pc_next_calc (
        .pc      (PC),
        .pc_sel  (pc_sel_t'(PC_SEL)),
        .imm     (IMM),
        .stat    (STAT),
        .mm      (MM),
        .next_pc (pc_next)
    );

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            PC <= RESET_PC;
        end else if (PC_WE) begin
            PC <= pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetch + PC update vectors,
// hand-written sequences for mid-fetch PC writes, re-pulses and reset.
module tb_fetch_unit;

    logic        CLK;
    logic        RST_F;
    logic        FETCH_EN;
    logic        PC_WE;
    logic [1:0]  PC_SEL;
    logic [3:0]  STAT;
    logic [31:0] IR;
    logic [3:0]  OPCODE;
    logic [3:0]  MM;
    logic [15:0] IMM;
    logic        IR_VALID;
    logic        BUSY;
    logic [15:0] PC;

    int checks;
    int errors;
    int acc_count;
    logic [31:0] sb_q[$];
    logic [31:0] sb_exp;
    logic [15:0] model_pc;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  sel;
        logic [3:0]  stat;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[7];

    fetch_unit_if #(.PC_W(16)) imem_bus ();

    fetch_unit #(
        .PC_W     (16),
        .RESET_PC (16'h0000)
    ) dut (
        .CLK      (CLK),
        .RST_F    (RST_F),
        .FETCH_EN (FETCH_EN),
        .PC_WE    (PC_WE),
        .PC_SEL   (PC_SEL),
        .STAT     (STAT),
        .imem     (imem_bus),
        .IR       (IR),
        .OPCODE   (OPCODE),
        .MM       (MM),
        .IMM      (IMM),
        .IR_VALID (IR_VALID),
        .BUSY     (BUSY),
        .PC       (PC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic fe, input logic we, input logic [1:0] sel,
                                 input logic [3:0] st, input logic ack, input logic [31:0] rd);
        FETCH_EN            = fe;
        PC_WE               = we;
        PC_SEL              = sel;
        STAT                = st;
        imem_bus.IMEM_ACK   = ack;
        imem_bus.IMEM_RDATA = rd;
    endtask

    // Scoreboard consumer: every accepted ACK must match the oldest queued word.
    always @(posedge CLK) begin
        if (RST_F && imem_bus.IMEM_REQ && imem_bus.IMEM_ACK) begin
            acc_count++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_underflow: got an accepted ACK, expected none");
            end else begin
                sb_exp = sb_q.pop_front();
                #1;
                checkOutput("sb_ir", IR, sb_exp);
                checkOutput("sb_opcode", {28'h0, OPCODE}, {28'h0, sb_exp[31:28]});
                checkOutput("sb_mm", {28'h0, MM}, {28'h0, sb_exp[27:24]});
                checkOutput("sb_imm", {16'h0, IMM}, {16'h0, sb_exp[15:0]});
            end
        end
    end

    // One complete fetch with ACK returned lat cycles after the first REQ cycle.
    task automatic doFetch(input logic [31:0] rd, input int lat, input logic [15:0] addr);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'h0, 1'b0, 32'h0);
        sb_q.push_back(rd);
        @(negedge CLK);
        FETCH_EN = 1'b0;
        for (int c = 0; c <= lat; c++) begin
            checkOutput("req_held", {31'h0, imem_bus.IMEM_REQ}, 32'h1);
            checkOutput("busy_held", {31'h0, BUSY}, 32'h1);
            checkOutput("addr_stable", {16'h0, imem_bus.IMEM_ADDR}, {16'h0, addr});
            if (c == lat) begin
                imem_bus.IMEM_ACK   = 1'b1;
                imem_bus.IMEM_RDATA = rd;
            end
            @(negedge CLK);
        end
        imem_bus.IMEM_ACK   = 1'b0;
        imem_bus.IMEM_RDATA = $urandom;
        checkOutput("req_drop", {31'h0, imem_bus.IMEM_REQ}, 32'h0);
        checkOutput("ir_valid_set", {31'h0, IR_VALID}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        checks    = 0;
        errors    = 0;
        acc_count = 0;
        vecs[0] = '{32'h0000_0010, 2'b01, 4'h0, 16'h0010};
        vecs[1] = '{32'h0000_FFFE, 2'b10, 4'h0, 16'h000E};
        vecs[2] = '{32'h0000_FFFF, 2'b01, 4'h0, 16'hFFFF};
        vecs[3] = '{32'h0000_0000, 2'b00, 4'h0, 16'h0000};
        vecs[4] = '{32'h6200_0004, 2'b11, 4'h2, 16'h0001};
        vecs[5] = '{32'h5000_FFFF, 2'b11, 4'hF, 16'h0000};
        vecs[6] = '{32'h6200_0005, 2'b11, 4'h1, 16'h0005};

        RST_F = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 32'h0);
        repeat (3) @(negedge CLK);
        checkOutput("rst_pc", {16'h0, PC}, 32'h0);
        checkOutput("rst_ir", IR, 32'h0);
        checkOutput("rst_ir_valid", {31'h0, IR_VALID}, 32'h0);
        checkOutput("rst_req", {31'h0, imem_bus.IMEM_REQ}, 32'h0);
        checkOutput("rst_addr", {16'h0, imem_bus.IMEM_ADDR}, 32'h0);
        RST_F = 1'b1;
        @(negedge CLK);

        // Fetch with ACK in the fourth REQ cycle.
        doFetch(32'h8100_0005, 3, 16'h0000);
        checkOutput("first_opcode", {28'h0, OPCODE}, 32'h8);
        checkOutput("first_mm", {28'h0, MM}, 32'h1);
        model_pc = 16'h0000;

        for (int i = 0; i < 7; i++) begin
            doFetch(vecs[i].rdata, i % 3, model_pc);
            applyStimulus(1'b0, 1'b1, vecs[i].sel, vecs[i].stat, 1'b0, 32'h0);
            @(negedge CLK);
            PC_WE = 1'b0;
            checkOutput($sformatf("pc_update_%0d", i), {16'h0, PC}, {16'h0, vecs[i].exp_pc});
            model_pc = vecs[i].exp_pc;
        end

        // PC write during REQ must not move the in-flight address.
        doFetch(32'h1000_0040, 1, 16'h0005);
        FETCH_EN = 1'b1;
        sb_q.push_back(32'hF000_0000);
        @(negedge CLK);
        FETCH_EN = 1'b0;
        checkOutput("midreq_addr0", {16'h0, imem_bus.IMEM_ADDR}, 32'h5);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 1'b0, 32'h0);
        @(negedge CLK);
        PC_WE = 1'b0;
        checkOutput("midreq_pc", {16'h0, PC}, 32'h40);
        checkOutput("midreq_addr1", {16'h0, imem_bus.IMEM_ADDR}, 32'h5);
        checkOutput("midreq_req", {31'h0, imem_bus.IMEM_REQ}, 32'h1);
        imem_bus.IMEM_ACK   = 1'b1;
        imem_bus.IMEM_RDATA = 32'hF000_0000;
        @(negedge CLK);
        imem_bus.IMEM_ACK = 1'b0;
        checkOutput("midreq_done", {31'h0, imem_bus.IMEM_REQ}, 32'h0);
        checkOutput("midreq_pc_keep", {16'h0, PC}, 32'h40);

        // FETCH_EN and PC_WE on the same edge: fetch sees the old PC.
        applyStimulus(1'b1, 1'b1, 2'b00, 4'h0, 1'b0, 32'h0);
        sb_q.push_back(32'h2000_1234);
        @(negedge CLK);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 32'h0);
        checkOutput("same_edge_addr", {16'h0, imem_bus.IMEM_ADDR}, 32'h40);
        checkOutput("same_edge_pc", {16'h0, PC}, 32'h41);
        checkOutput("same_edge_valid_clr", {31'h0, IR_VALID}, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 1'b1, 32'h2000_1234);
        @(negedge CLK);
        imem_bus.IMEM_ACK = 1'b0;

        // Re-pulsing FETCH_EN while busy yields a single transaction.
        base = acc_count;
        FETCH_EN = 1'b1;
        sb_q.push_back(32'h8300_0000);
        @(negedge CLK);
        FETCH_EN = 1'b0;
        @(negedge CLK);
        FETCH_EN = 1'b1;
        @(negedge CLK);
        FETCH_EN = 1'b0;
        checkOutput("repulse_addr", {16'h0, imem_bus.IMEM_ADDR}, 32'h41);
        checkOutput("repulse_valid_low", {31'h0, IR_VALID}, 32'h0);
        imem_bus.IMEM_ACK   = 1'b1;
        imem_bus.IMEM_RDATA = 32'h8300_0000;
        @(negedge CLK);
        imem_bus.IMEM_ACK = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("repulse_idle_req", {31'h0, imem_bus.IMEM_REQ}, 32'h0);
            checkOutput("repulse_valid_hold", {31'h0, IR_VALID}, 32'h1);
            @(negedge CLK);
        end
        checkOutput("repulse_txn_count", acc_count - base, 32'h1);

        // ACK while idle leaves IR alone.
        applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 1'b1, 32'hDEAD_BEEF);
        @(negedge CLK);
        imem_bus.IMEM_ACK = 1'b0;
        checkOutput("idle_ack_ir", IR, 32'h8300_0000);

        // Reset mid-fetch abandons the request at once; a late ACK is dropped.
        FETCH_EN = 1'b1;
        sb_q.push_back(32'h4000_0000);
        @(negedge CLK);
        FETCH_EN = 1'b0;
        checkOutput("prerst_req", {31'h0, imem_bus.IMEM_REQ}, 32'h1);
        RST_F = 1'b0;
        #1;
        checkOutput("midrst_req", {31'h0, imem_bus.IMEM_REQ}, 32'h0);
        checkOutput("midrst_busy", {31'h0, BUSY}, 32'h0);
        checkOutput("midrst_pc", {16'h0, PC}, 32'h0);
        void'(sb_q.pop_back());
        imem_bus.IMEM_ACK   = 1'b1;
        imem_bus.IMEM_RDATA = 32'hABCD_0001;
        @(negedge CLK);
        imem_bus.IMEM_ACK = 1'b0;
        @(negedge CLK);
        checkOutput("midrst_ir", IR, 32'h0);
        checkOutput("midrst_ir_valid", {31'h0, IR_VALID}, 32'h0);
        RST_F = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("postrst_req", {31'h0, imem_bus.IMEM_REQ}, 32'h0);
        checkOutput("sb_empty", sb_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
